// File: rtl/cl_pcis_scratch_mem_if.sv
// AXI4 slave-side bundle for the PCIS scratch memory: AW, W, B, AR and R channels.
interface cl_pcis_scratch_mem_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 6
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/cl_pcis_scratch_mem.sv
// PCIS scratch memory: DEPTH x DATA_WIDTH word store behind an AXI4 INCR-only slave.
// Independent write and read FSMs share the array; reads load rdata only on handshake.
//
// state  | meaning
// W_IDLE | waiting for a write address; awready high
// W_DATA | accepting awlen+1 write beats; wready high
// W_RESP | presenting the write response until bready
// R_IDLE | waiting for a read address; arready high
// R_DATA | presenting read beats; rvalid high until the final beat is taken
module cl_pcis_scratch_mem #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 6,
    parameter int DEPTH      = 64
) (
    input logic clk,
    input logic rst_n,
    cl_pcis_scratch_mem_if.slave s_axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BO_W  = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Ready outputs stay low until the first edge that samples rst_n high.
    logic live_q;

    w_state_t              w_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [IDX_W-1:0]      w_idx_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_cnt_q;
    logic                  w_err_q;

    r_state_t              r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [IDX_W-1:0]      r_idx_q;
    logic [7:0]            r_len_q;
    logic [7:0]            r_cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_final, r_final;

    logic [IDX_W-1:0] aw_start, ar_start;

    // Size fields and out-of-range address bits play no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

    assign aw_start = s_axi.awaddr[BO_W +: IDX_W];
    assign ar_start = s_axi.araddr[BO_W +: IDX_W];

    assign aw_hs   = s_axi.awvalid && s_axi.awready;
    assign w_hs    = s_axi.wvalid  && s_axi.wready;
    assign b_hs    = s_axi.bvalid  && s_axi.bready;
    assign ar_hs   = s_axi.arvalid && s_axi.arready;
    assign r_hs    = s_axi.rvalid  && s_axi.rready;
    assign w_final = (w_cnt_q == w_len_q);
    assign r_final = (r_cnt_q == r_len_q);

    // Track whether reset has been released for at least one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    // ---------------- write channel ----------------

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Write FSM next state: beat count alone ends the burst, wlast is only checked.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)            w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final)  w_state_nxt = W_RESP;
            W_RESP:  if (b_hs)             w_state_nxt = W_IDLE;
            default:                       w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        s_axi.awready = live_q && (w_state == W_IDLE);
        s_axi.wready  = (w_state == W_DATA);
        s_axi.bvalid  = (w_state == W_RESP);
        s_axi.bid     = aw_id_q;
        s_axi.bresp   = w_err_q ? 2'b10 : 2'b00;
    end

    // Write burst bookkeeping: index, beat count and wlast consistency flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_id_q <= '0;
            w_idx_q <= '0;
            w_len_q <= '0;
            w_cnt_q <= '0;
            w_err_q <= 1'b0;
        end else if (aw_hs) begin
            aw_id_q <= s_axi.awid;
            w_idx_q <= aw_start;
            w_len_q <= s_axi.awlen;
            w_cnt_q <= '0;
            w_err_q <= 1'b0;
        end else if (w_hs) begin
            w_idx_q <= w_idx_q + IDX_W'(1);
            w_cnt_q <= w_cnt_q + 8'd1;
            if (s_axi.wlast != w_final) w_err_q <= 1'b1;
        end
    end

    // Byte-strobed store into the array; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Read FSM next state.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)            r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_final)  r_state_nxt = R_IDLE;
            default:                       r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        s_axi.arready = live_q && (r_state == R_IDLE);
        s_axi.rvalid  = (r_state == R_DATA);
        s_axi.rlast   = (r_state == R_DATA) && r_final;
        s_axi.rid     = ar_id_q;
        s_axi.rresp   = 2'b00;
        s_axi.rdata   = rdata_q;
    end

    // Read beat register: loaded at AR handshake and after each non-final R handshake,
    // so a stalled beat holds and same-cycle writes are seen only by later beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_id_q <= '0;
            r_idx_q <= '0;
            r_len_q <= '0;
            r_cnt_q <= '0;
            rdata_q <= '0;
        end else if (ar_hs) begin
            ar_id_q <= s_axi.arid;
            rdata_q <= mem[ar_start];
            r_idx_q <= ar_start + IDX_W'(1);
            r_len_q <= s_axi.arlen;
            r_cnt_q <= '0;
        end else if (r_hs && !r_final) begin
            rdata_q <= mem[r_idx_q];
            r_idx_q <= r_idx_q + IDX_W'(1);
            r_cnt_q <= r_cnt_q + 8'd1;
        end
    end
endmodule

// File: doc/cl_pcis_scratch_mem.md
CL_PCIS_SCRATCH_MEM -- requirements
Module: cl_pcis_scratch_mem

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH, 512, AXI data width in bits; power of two, >=32.
  ADDR_WIDTH, 64, AXI address width.
  ID_WIDTH, 6, AXI ID width.
  DEPTH, 64, storage depth in DATA_WIDTH words; power of two, 2..1024.
REQ-002 Ports (name  direction  width  meaning), one per line, clock and reset first:
  clk  in  1  single clock; all logic on its rising edge.
  rst_n  in  1  reset; synchronous, active-low.
  s_axi_awid/awaddr/awlen/awsize/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/1  write address.
  s_axi_awready  out  1  write address ready.
  s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
  s_axi_wready  out  1  write data ready.
  s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1  write response.
  s_axi_bready  in  1  write response ready.
  s_axi_arid/araddr/arlen/arsize/arvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/1  read address.
  s_axi_arready  out  1  read address ready.
  s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data.
  s_axi_rready  in  1  read data ready.

Function
REQ-003 Storage: DEPTH x DATA_WIDTH array, combinational read, not reset; word index = addr[log2(DATA_WIDTH/8) +: log2(DEPTH)]; higher address bits ignored.
REQ-004 Bursts: INCR only; awsize/arsize ignored, every beat full width; beats = len+1 (1..256); index increments per beat, wraps DEPTH-1 -> 0.
REQ-005 Write FSM states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-006 W_IDLE: on awvalid&&awready latch awid, start index, awlen, clear beat counter and error flag; -> W_DATA next cycle.
REQ-007 W_DATA: each wvalid&&wready beat writes byte b of the current word iff wstrb[b]=1, then index+1, counter+1.
REQ-008 Beat number awlen+1 is final: -> W_RESP next cycle regardless of wlast.
REQ-009 wlast=1 on a non-final beat, or wlast=0 on the final beat, sets the error flag; beats never terminate early.
REQ-010 W_RESP: bid=latched awid, bresp=2'b10 (SLVERR) if error flag else 2'b00; hold until bready; on bvalid&&bready -> W_IDLE.
REQ-011 Read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE; on arvalid&&arready latch arid, start index, arlen; -> R_DATA.
REQ-012 R_DATA: rvalid=1 from the cycle after AR handshake; rdata registered from array; rresp=2'b00; rid=latched arid; rlast=1 only on beat arlen+1.
REQ-013 rdata/rid/rlast/rresp SHALL hold stable while rvalid&&!rready; on handshake next beat is presented the following cycle (one beat per cycle sustained).
REQ-014 Final beat handshake -> R_IDLE; rvalid and rlast deassert next cycle; arready=1 that cycle.
REQ-015 Read and write FSMs are independent and may run concurrently.
REQ-016 Same-cycle write to word k and rdata load from word k: rdata takes pre-write contents.
REQ-017 Read beats are loaded from the array on handshake only; writes during a stalled beat do not alter the held rdata.

Reset
REQ-018 rst_n=0 sampled at a clk edge: both FSMs -> IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0.
REQ-019 awready/arready SHALL assert on the first clk edge after rst_n samples 1.
REQ-020 Reset mid-burst abandons the burst with no response; stored words already written are retained.

Verification
REQ-021 Write 4 beats at awaddr 0x0 (awlen=3, awid=0x05, wstrb all 1), read back arlen=3 arid=0x09 -> four words in order, rlast on 4th, rid=0x09, bid=0x05, bresp=rresp=0.
REQ-022 DEPTH=64: write 3 beats at word 62 -> words 62, 63, 0 written; read 3 beats at word 62 returns same order.
REQ-023 Write single beat with wstrb=0x...000F over known pattern -> only bytes 0-3 change on readback.
REQ-024 awlen=1 with wlast asserted on beat 1 -> both beats written, bresp=2'b10; bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready=0 throughout.
REQ-025 8-beat read with rready toggling 1/0 each cycle while a concurrent write burst targets other words -> rdata stable across stalls, 8 beats in order, write completes with bresp=0.
REQ-026 Assert rst_n=0 during beat 2 of a 4-beat read -> next cycle rvalid=0, rlast=0; after release arready=1 on first cycle and a new read completes normally.
